tt_hybrid_adder: RTL and testbench
==================================

TT_HYBRID_ADDER -- requirements
Module: tt_hybrid_adder

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset: clk is the clock, rst_n is the reset (0 = reset asserted).
REQ-002 clk  input  1  rising-edge system clock.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 ena  input  1  design enable; 1 = registers update, 0 = registers hold.
REQ-005 ui_in  input  8  operand A[7:0].
REQ-006 uio_in  input  8  operand B[7:0].
REQ-007 uo_out  output  8  registered sum S[7:0].
REQ-008 uio_out  output  8  constant 8'h00.
REQ-009 uio_oe  output  8  constant 8'h00; all bidirectional pins are inputs.

Function
REQ-010 The block SHALL compute S = (A + B) mod 256, unsigned, with carry-in 0.
- Carry-out of bit 7 is discarded and not exported.
REQ-011 The adder datapath SHALL be hybrid:
- Low nibble: 4-bit ripple-carry adder on A[3:0] + B[3:0] with cin 0, producing c4.
- High nibble: two 4-bit ripple-carry adders on A[7:4] + B[7:4], one with cin 0 and one with cin 1.
- A 2:1 mux selected by c4 chooses the high-nibble result (carry-select).
REQ-012 The sum SHALL be captured into an 8-bit output register on the rising clk edge when ena = 1; uo_out SHALL be driven only from that register.
REQ-013 Without INPUT_REG_EN, latency SHALL be 1 cycle: A/B sampled at edge N appear on uo_out after edge N.
REQ-014 When ena = 0, all internal registers SHALL hold; uo_out SHALL keep its last value.
REQ-015 Overflow SHALL wrap modulo 256.
- 8'hFF + 8'h01 = 8'h00.
- 8'h80 + 8'h80 = 8'h00.
REQ-016 Operand changes between clock edges SHALL have no effect until the next enabled edge.

Reset
REQ-017 While rst_n = 0, every internal register SHALL be 0 and uo_out SHALL read 8'h00, independent of clk and ena.
REQ-018 Reset asserted mid-operation SHALL clear all registers immediately; any in-flight sum SHALL be lost.
REQ-019 After rst_n rises, the first enabled edge SHALL resume normal operation per REQ-013 or REQ-021.

Configuration
REQ-020 Macro INPUT_REG_EN SHALL select an optional input register stage.
REQ-021 With INPUT_REG_EN defined:
- A and B SHALL be registered on an enabled edge before the adder.
- Latency SHALL be 2 enabled cycles.
- Input registers SHALL reset to 0 and obey ena.
REQ-022 Without INPUT_REG_EN, the adder SHALL be fed directly from ui_in/uio_in, with latency per REQ-013.

Structure
REQ-023 Package hybrid_adder_pkg SHALL hold WIDTH = 8 and NIBBLE = 4.
REQ-024 Sub-module hybrid_rca4 (4-bit ripple-carry adder: a, b, cin -> sum[3:0], cout) SHALL be instantiated three times.
REQ-025 The carry-select mux and all registers SHALL reside in tt_hybrid_adder.

Verification
REQ-026 Reset: rst_n = 0 with A = 8'h55, B = 8'h22 -> uo_out = 8'h00 throughout; after release, the next enabled edge(s) -> 8'h77.
REQ-027 No-carry and select paths: 8'h12 + 8'h34 -> 8'h46; 8'h0F + 8'h01 -> 8'h10 (c4 = 1 selects the cin 1 high result).
REQ-028 Wrap: 8'hFF + 8'h01 -> 8'h00; 8'hC8 + 8'h64 -> 8'h2C.
REQ-029 Hold: set 8'h10 + 8'h20, then ena = 0 and change operands to 8'h01 + 8'h01 -> uo_out stays 8'h30; ena = 1 -> 8'h02 after the configured latency.
REQ-030 Exhaustive: all 65536 A/B pairs, checked against the (A + B) & 8'hFF model at the configured latency (1 or 2), both with and without INPUT_REG_EN.
REQ-031 Async reset: assert rst_n between clk edges -> uo_out = 8'h00 before the next clk edge.

Source files
------------

// File: rtl/hybrid_adder_pkg.sv
// hybrid_adder_pkg: shared widths for the carry-select hybrid adder.
package hybrid_adder_pkg;
   localparam int WIDTH  = 8;
   localparam int NIBBLE = 4;
endpackage

// File: rtl/hybrid_rca4.sv
// hybrid_rca4: 4-bit ripple-carry adder used for each nibble of the hybrid adder.
module hybrid_rca4
   import hybrid_adder_pkg::*;
(
   input  logic [NIBBLE-1:0] a,
   input  logic [NIBBLE-1:0] b,
   input  logic              cin,
   output logic [NIBBLE-1:0] sum,
   output logic              cout
);
   logic [NIBBLE:0] c;
   assign c[0] = cin;
   for (genvar i = 0; i < NIBBLE; i++) begin : g_fa
      assign sum[i]  = a[i] ^ b[i] ^ c[i];
      assign c[i+1]  = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
   end
   assign cout = c[NIBBLE];
endmodule

// File: rtl/tt_hybrid_adder.sv
// tt_hybrid_adder: registered 8-bit carry-select adder (ripple nibbles, muxed high half).
// Define INPUT_REG_EN to add an operand register stage (latency 2 instead of 1).
module tt_hybrid_adder
   import hybrid_adder_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ena,
   input  logic [WIDTH-1:0] ui_in,
   input  logic [WIDTH-1:0] uio_in,
   output logic [WIDTH-1:0] uo_out,
   output logic [WIDTH-1:0] uio_out,
   output logic [WIDTH-1:0] uio_oe
);
   logic [WIDTH-1:0]  a, b, sum_q;
   logic [NIBBLE-1:0] lo, hi0, hi1;
   logic              c4, unused_co0, unused_co1;
`ifdef INPUT_REG_EN
   logic [WIDTH-1:0] a_q, b_q;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         a_q <= '0;
         b_q <= '0;
      end else if (ena) begin
         a_q <= ui_in;
         b_q <= uio_in;
      end
   assign a = a_q;
   assign b = b_q;
`else
   assign a = ui_in;
   assign b = uio_in;
`endif
   hybrid_rca4 u_lo  (.a(a[NIBBLE-1:0]), .b(b[NIBBLE-1:0]), .cin(1'b0), .sum(lo), .cout(c4));
   hybrid_rca4 u_hi0 (.a(a[WIDTH-1:NIBBLE]), .b(b[WIDTH-1:NIBBLE]), .cin(1'b0), .sum(hi0), .cout(unused_co0));
   hybrid_rca4 u_hi1 (.a(a[WIDTH-1:NIBBLE]), .b(b[WIDTH-1:NIBBLE]), .cin(1'b1), .sum(hi1), .cout(unused_co1));
   // Carry-out of bit 7 is discarded, so the high adders' couts go nowhere.
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n)
         sum_q <= '0;
      else if (ena)
         sum_q <= {c4 ? hi1 : hi0, lo};
   assign uo_out  = sum_q;
   assign uio_out = '0;
   assign uio_oe  = '0;
endmodule

// File: tb/tb_tt_hybrid_adder.sv
// tb_tt_hybrid_adder: directed vector table plus reset/hold/async and exhaustive sweeps.
module tb_tt_hybrid_adder;
`ifdef INPUT_REG_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif
   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] exp;
   } vec_t;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       ena = 1'b1;
   logic [7:0] ui_in = '0, uio_in = '0;
   logic [7:0] uo_out, uio_out, uio_oe;
   int         checks = 0, errors = 0;
   vec_t       tbl [12];
   logic [7:0] q [$];
   tt_hybrid_adder dut (
      .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
      .uo_out(uo_out), .uio_out(uio_out), .uio_oe(uio_oe)
   );
   always #5 clk = ~clk;
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask
   task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask
   initial begin
      int bad;
      logic [7:0] e;
      tbl[0]  = '{8'h12, 8'h34, 8'h46};
      tbl[1]  = '{8'h0F, 8'h01, 8'h10};
      tbl[2]  = '{8'hFF, 8'h01, 8'h00};
      tbl[3]  = '{8'hC8, 8'h64, 8'h2C};
      tbl[4]  = '{8'h80, 8'h80, 8'h00};
      tbl[5]  = '{8'h00, 8'h00, 8'h00};
      tbl[6]  = '{8'hFF, 8'hFF, 8'hFE};
      tbl[7]  = '{8'h08, 8'h08, 8'h10};
      tbl[8]  = '{8'hF0, 8'h10, 8'h00};
      tbl[9]  = '{8'h7F, 8'h01, 8'h80};
      tbl[10] = '{8'h55, 8'hAA, 8'hFF};
      tbl[11] = '{8'h99, 8'h77, 8'h10};
      // Reset holds output at zero even with enabled clocks and live operands.
      ui_in = 8'h55;
      uio_in = 8'h22;
      #1;
      chk("reset_initial", uo_out, 8'h00);
      chk("uio_out", uio_out, 8'h00);
      chk("uio_oe", uio_oe, 8'h00);
      ticks(3);
      chk("reset_held", uo_out, 8'h00);
      rst_n = 1'b1;
      ticks(LAT);
      chk("reset_release", uo_out, 8'h77);
      for (int i = 0; i < 12; i++) begin
         ui_in = tbl[i].a;
         uio_in = tbl[i].b;
         ticks(LAT);
         chk($sformatf("vec%0d", i), uo_out, tbl[i].exp);
      end
      // Hold: operands change while disabled must not reach the output.
      ui_in = 8'h10;
      uio_in = 8'h20;
      ticks(LAT);
      chk("hold_setup", uo_out, 8'h30);
      ena = 1'b0;
      ui_in = 8'h01;
      uio_in = 8'h01;
      ticks(3);
      chk("hold_stay", uo_out, 8'h30);
      ena = 1'b1;
      ticks(LAT);
      chk("hold_resume", uo_out, 8'h02);
      // Async reset between edges clears output before the next edge.
      ui_in = 8'h12;
      uio_in = 8'h34;
      ticks(LAT);
      chk("async_pre", uo_out, 8'h46);
      #2 rst_n = 1'b0;
      #1;
      chk("async_clear", uo_out, 8'h00);
      #3 rst_n = 1'b1;
      ticks(LAT);
      chk("async_resume", uo_out, 8'h46);
      // Exhaustive pipelined sweep, one pair per cycle.
      bad = 0;
      for (int i = 0; i < 65536; i++) begin
         ui_in = i[15:8];
         uio_in = i[7:0];
         e = i[15:8] + i[7:0];
         q.push_back(e);
         tick();
         if (q.size() == LAT) begin
            e = q.pop_front();
            if (uo_out !== e) bad++;
         end
      end
      while (q.size() > 0) begin
         tick();
         e = q.pop_front();
         if (uo_out !== e) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL exhaustive: %0d mismatching pairs, expected 0", bad);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
